v_instr_queue: RTL
==================

V_INSTR_QUEUE -- requirements
Module: v_instr_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the FIFO entry count; it must be a power of two and at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port s_instr_vld_i, input, 1 bit: the scalar core offers a vector instruction.
REQ-005 The block SHALL have port s_instr_i, input, 32 bits: the offered vector instruction word.
REQ-006 The block SHALL have ports s_rs1_i and s_rs2_i, input, 32 bits each: scalar operands captured with the instruction.
REQ-007 The block SHALL have port s_rdy_o, output, 1 bit: the queue can accept an entry this cycle.
REQ-008 The block SHALL have port vector_instr_o, output, 32 bits: the head instruction presented to the scheduler.
REQ-009 The block SHALL have ports rs1_o and rs2_o, output, 32 bits each: the head operands.
REQ-010 The block SHALL have port sew_o, output, 2 bits: the current element width for the scheduler's sew input.
REQ-011 The block SHALL have port vector_stall_i, input, 1 bit: the scheduler is not consuming its input this cycle.
REQ-012 The block SHALL have port sched_insert_i, input, 1 bit: the scheduler is substituting an internally generated indexed-load part-2 word, so the head is not consumed.
REQ-013 The block SHALL have port count_o, output, $clog2(DEPTH)+1 bits: the number of valid entries.

Function
REQ-014 Push SHALL occur when s_instr_vld_i && s_rdy_o; the entry stored is {s_instr_i, s_rs1_i, s_rs2_i}.
REQ-015 s_rdy_o SHALL equal (count_o != DEPTH); there is no full-bypass, so a push cannot be accepted while full even if a pop occurs in the same cycle.
REQ-016 Pop SHALL occur when (count_o != 0) && !vector_stall_i && !sched_insert_i.
REQ-017 When non-empty, vector_instr_o, rs1_o and rs2_o SHALL show the head entry; when empty they SHALL be 32'h0 (opcode 0 is a no-op to the scheduler).
REQ-018 A push into an empty queue SHALL be visible at the outputs in the next cycle (1-cycle latency, no write-through).
REQ-019 On a simultaneous push and pop with 0 < count < DEPTH, count_o SHALL be unchanged, and the order SHALL be preserved.
REQ-020 Read and write pointers SHALL be $clog2(DEPTH) bits and SHALL wrap modulo DEPTH; full and empty SHALL be derived from count, not from pointer equality.
REQ-021 A config instruction SHALL be recognised when opcode [6:0] == v_arith_opcode and funct3 [14:12] == OPCFG.
REQ-022 On the pop of a config instruction, sew_o SHALL update in the following cycle, as follows:
- vsetvli (bit31 = 0) and vsetivli (bits31:30 = 2'b11): sew_o = instr[24:23].
- vsetvl (bits31:30 = 2'b10): sew_o = rs2[4:3].
REQ-023 sew_o SHALL NOT change on a push, on a stalled head, or on the pop of a non-config instruction.
REQ-024 No output SHALL depend combinationally on s_instr_i, s_rs1_i or s_rs2_i; s_rdy_o SHALL depend only on state.

Reset
REQ-025 While rstn is low at a clock edge, the block SHALL set pointers to 0, count_o to 0, sew_o to 2'b00, and s_rdy_o to 1; instruction outputs read 32'h0.
REQ-026 A reset asserted mid-operation SHALL discard all entries, including any push or pop in the same cycle; FIFO storage contents need no reset.

Structure
REQ-027 The constants v_arith_opcode and OPCFG SHALL come from typedef_pkg; a new OPCFG sub-encoding enum (VSETVLI, VSETIVLI, VSETVL) SHALL be added to typedef_pkg.
REQ-028 Storage and pointers SHALL be one sub-module, v_instr_fifo (parameterised width and DEPTH); config decode and the sew register SHALL stay in v_instr_queue.

Verification
REQ-029 Fill to full: push 5 instrs with DEPTH=4 and vector_stall_i=1 -> 4 accepted, s_rdy_o=0 after the 4th, count_o=4, 5th held by the core.
REQ-030 Order and latency: push A at cycle 0 into an empty queue with no stall -> vector_instr_o=A at cycle 1, 32'h0 at cycle 2 if nothing else is pushed.
REQ-031 Stall and insert: head B with vector_stall_i=1 for 3 cycles, then sched_insert_i=1 for 1 cycle -> B is held for all 4 cycles and popped on the 5th.
REQ-032 SEW tracking: pop vsetvli with instr[24:23]=2'b10 -> sew_o=2'b10 the next cycle; pop vsetvl with rs2=32'h18 -> sew_o=2'b11; pop vadd -> sew_o unchanged.
REQ-033 Wrap-around: 10 interleaved push/pop cycles at count=2 -> output sequence equals input sequence, and count_o stays at 2.
REQ-034 Mid-operation reset: rstn low for 1 cycle at count=3 -> count_o=0, s_rdy_o=1, sew_o=2'b00, vector_instr_o=32'h0.

Source files
------------

// File: rtl/typedef_pkg.sv
// Shared vector-unit encodings.
//   v_arith_opcode : major opcode of the vector arithmetic/config space
//   OPCFG          : funct3 marking a vector configuration instruction
//   opcfg_e        : which of the three config forms an OPCFG word is
//   q_entry_t      : one instruction-queue entry {instr, rs1, rs2}
package typedef_pkg;

    localparam logic [6:0] v_arith_opcode = 7'b1010111;
    localparam logic [2:0] OPCFG          = 3'b111;

    typedef enum logic [1:0] {
        VSETVLI  = 2'd0,
        VSETIVLI = 2'd1,
        VSETVL   = 2'd2
    } opcfg_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } q_entry_t;

    // Classify a config word from its top two bits:
    // bit31 = 0 -> vsetvli, 2'b11 -> vsetivli, 2'b10 -> vsetvl.
    function automatic opcfg_e cfg_kind(input logic [1:0] top2);
        if (!top2[1])
            return VSETVLI;
        else if (top2[0])
            return VSETIVLI;
        else
            return VSETVL;
    endfunction

endpackage

// File: rtl/v_instr_fifo.sv
// Circular FIFO holding queued vector instructions.
// Ports:
//   clk, rstn   : clock and synchronous active-low reset
//   push, wdata : write an entry (caller guarantees not full)
//   pop         : drop the head entry (caller guarantees not empty)
//   rdata       : current head entry (undefined contents when empty)
//   count       : number of valid entries, 0..DEPTH
module v_instr_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;

    // Storage is not reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= wdata;
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + PW'(1);
            if (pop)
                rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rptr];

endmodule

// File: rtl/v_instr_queue.sv
// Decoupling queue between the scalar core and the vector scheduler.
// Also tracks the current element width by watching config instructions
// leave the queue.
// Ports:
//   clk, rstn                    : clock and synchronous active-low reset
//   s_instr_vld_i, s_instr_i     : instruction offered by the scalar core
//   s_rs1_i, s_rs2_i             : scalar operands captured with it
//   s_rdy_o                      : queue not full (state only)
//   vector_instr_o, rs1_o, rs2_o : head entry, all zero when empty
//   sew_o                        : element width from the last popped config
//   vector_stall_i               : scheduler not consuming this cycle
//   sched_insert_i               : scheduler injecting its own word; hold head
//   count_o                      : number of valid entries
module v_instr_queue
    import typedef_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     s_instr_vld_i,
    input  logic [31:0]              s_instr_i,
    input  logic [31:0]              s_rs1_i,
    input  logic [31:0]              s_rs2_i,
    output logic                     s_rdy_o,
    output logic [31:0]              vector_instr_o,
    output logic [31:0]              rs1_o,
    output logic [31:0]              rs2_o,
    output logic [1:0]               sew_o,
    input  logic                     vector_stall_i,
    input  logic                     sched_insert_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    q_entry_t wr_entry;
    q_entry_t fifo_head;
    q_entry_t head;
    logic     push;
    logic     pop;
    logic     not_empty;
    logic     head_is_cfg;

    assign not_empty = (count_o != '0);

    // No full-bypass: a pop in the same cycle does not free a slot.
    assign s_rdy_o = (count_o != CW'(DEPTH));
    assign push    = s_instr_vld_i && s_rdy_o;
    assign pop     = not_empty && !vector_stall_i && !sched_insert_i;

    assign wr_entry = '{instr: s_instr_i, rs1: s_rs1_i, rs2: s_rs2_i};

    v_instr_fifo #(
        .WIDTH ($bits(q_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (fifo_head),
        .count (count_o)
    );

    // Empty queue presents opcode 0, which the scheduler treats as a no-op.
    assign head = not_empty ? fifo_head : '0;

    assign vector_instr_o = head.instr;
    assign rs1_o          = head.rs1;
    assign rs2_o          = head.rs2;

    assign head_is_cfg = (head.instr[6:0] == v_arith_opcode) &&
                         (head.instr[14:12] == OPCFG);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sew_o <= 2'b00;
        end else if (pop && head_is_cfg) begin
            case (cfg_kind(head.instr[31:30]))
                VSETVL:  sew_o <= head.rs2[4:3];
                default: sew_o <= head.instr[24:23];
            endcase
        end
    end

endmodule
